// File: rtl/gate_bist.sv
// Built-in self-test engine for a 2-input combinational gate: walks the four
// input patterns, waits a settle time per pattern and checks the output against EXP_TABLE.
module gate_bist #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TABLE     = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       miss;
  logic [2:0] err_next;
  logic [1:0] idx_next;

  // Compare result for the pattern currently on the gate; err_next folds it in so
  // the final pass flag already accounts for the last pattern.
  always_comb begin
    miss     = dut_y ^ EXP_TABLE[idx];
    err_next = err_count + {2'b00, miss};
    idx_next = idx + 2'd1;
  end

  // Sequencer: pattern index, settle counter, gate drive and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_count <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SETTLE;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            dut_a     <= 1'b0;
            dut_b     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
          end else begin
            state <= state;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CHECK: begin
          fail_mask <= fail_mask | ({3'b000, miss} << idx);
          err_count <= err_next;
          if (idx == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
          end else begin
            // Next pattern goes onto the gate on this same edge.
            idx   <= idx_next;
            dut_a <= idx_next[1];
            dut_b <= idx_next[0];
            cnt   <= 4'd0;
            state <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: two instances (S=2/AND table, S=1/OR table)
// driven by a truth-table gate model and checked cycle by cycle against a reference.
module tb_gate_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [3:0] tt [2];
  wire  [1:0] a_w, b_w, y_w, busy_w, done_w, pass_w;
  wire  [3:0] fm_w [2];
  wire  [2:0] ec_w [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign y_w[0] = tt[0][{a_w[0], b_w[0]}];
  assign y_w[1] = tt[1][{a_w[1], b_w[1]}];

  gate_bist #(.SETTLE_CYCLES(2), .EXP_TABLE(4'b1000)) u_and (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_a(a_w[0]), .dut_b(b_w[0]),
    .dut_y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_mask(fm_w[0]), .err_count(ec_w[0])
  );

  gate_bist #(.SETTLE_CYCLES(1), .EXP_TABLE(4'b1110)) u_or (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_a(a_w[1]), .dut_b(b_w[1]),
    .dut_y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_mask(fm_w[1]), .err_count(ec_w[1])
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [3:0] exp_of(input int d);
    return (d == 0) ? 4'b1000 : 4'b1110;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input int d, input string tag, input logic a, input logic b,
                             input logic bz, input logic dn, input logic ps,
                             input logic [3:0] fm, input logic [2:0] ec);
    chk({tag, ".a"},    {7'd0, a_w[d]},    {7'd0, a});
    chk({tag, ".b"},    {7'd0, b_w[d]},    {7'd0, b});
    chk({tag, ".busy"}, {7'd0, busy_w[d]}, {7'd0, bz});
    chk({tag, ".done"}, {7'd0, done_w[d]}, {7'd0, dn});
    chk({tag, ".pass"}, {7'd0, pass_w[d]}, {7'd0, ps});
    chk({tag, ".fm"},   {4'd0, fm_w[d]},   {4'd0, fm});
    chk({tag, ".ec"},   {5'd0, ec_w[d]},   {5'd0, ec});
  endtask

  // Reference: after edge k+t, floor(t/(S+1)) patterns have been judged and the
  // pattern on the gate is min(floor(t/(S+1)), 3).
  task automatic check_at(input int d, input int t, input logic [3:0] ttv);
    int s, len, n, p, m;
    s   = settle_of(d);
    len = 4 * (s + 1);
    n   = t / (s + 1);
    if (n > 4) n = 4;
    p   = (n > 3) ? 3 : n;
    m   = ((1 << n) - 1) & int'(ttv ^ exp_of(d));
    chk_outputs(d, $sformatf("run%0d.t%0d", d, t), p[1], p[0], t < len, t == len,
                (t == len) && (m == 0), 4'(m), 3'($countones(m)));
  endtask

  // One full run on instance d; repulse_t >= 0 raises start for the edge after
  // that check. With hold_start, start stays high when the task returns.
  task automatic run(input int d, input logic [3:0] ttv, input int repulse_t, input bit hold_start);
    int len;
    len   = 4 * (settle_of(d) + 1);
    tt[d] = ttv;
    start_v[d] = 1'b1;
    tick();
    if (!hold_start) start_v[d] = 1'b0;
    for (int t = 0; t <= len; t++) begin
      check_at(d, t, ttv);
      if (t == repulse_t) start_v[d] = 1'b1;
      if (t == repulse_t + 1 && !hold_start) start_v[d] = 1'b0;
      if (t < len) tick();
    end
    if (!hold_start) start_v[d] = 1'b0;
  endtask

  initial begin
    int d, rt;
    logic [3:0] ttv;
    tt[0] = 4'b1000;
    tt[1] = 4'b1110;

    // Reset state
    #17;
    chk_outputs(0, "rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
    chk_outputs(1, "rst1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
    rst = 1'b0;
    tick();
    tick();
    chk_outputs(0, "idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);

    // Ideal AND, start re-pulsed mid-run (sampled at edge 5) is ignored
    run(0, 4'b1000, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outputs(0, "donehold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 3'd0);
    end

    // Restart from DONE: tied-0 output, then OR against the AND table
    run(0, 4'b0000, -1, 1'b0);
    run(0, 4'b1110, -1, 1'b0);

    // OR against the OR table, S=1
    run(1, 4'b1110, -1, 1'b0);
    run(1, 4'b0110, -1, 1'b0);

    // Back-to-back with start held: DONE lasts one cycle
    run(1, 4'b1110, -1, 1'b1);
    run(1, 4'b0001, -1, 1'b0);

    // Asynchronous reset mid-run
    tt[0] = 4'b0111;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int t = 0; t < 7; t++) tick();
    #2 rst = 1'b1;
    #1;
    chk_outputs(0, "midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_outputs(0, "postrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
    end
    run(0, 4'b0111, -1, 1'b0);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      d   = int'($urandom_range(0, 1));
      ttv = 4'($urandom);
      rt  = ($urandom_range(0, 1) == 0) ? -1
            : int'($urandom_range(0, 4 * (settle_of(d) + 1) - 1));
      run(d, ttv, rt, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
